// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-wide, big-endian data memory.
// Sub-word stores are done as a two-cycle read-modify-write with a pipeline stall.
module load_store_unit #(
    parameter int unsigned DEPTH_BITS = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Req,
    input  logic        IsStore,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Stall,
    output logic [31:0] LoadData,
    output logic        LoadValid,
    output logic        AddrError,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWriteEnable,
    input  logic [31:0] MemReadData
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [0:0] {IDLE, RMW_WRITE} state_t;

    state_t      state, state_nxt;
    logic [29:0] rmw_addr;
    logic [31:0] rmw_data;

    logic        bad;
    logic        size_ok;
    logic        take;
    logic        load_go;
    logic        err_go;
    logic        sw_go;
    logic        rmw_go;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Request qualification: only IDLE accepts; Size=10 is dropped silently.
    always_comb begin
        size_ok = (Size != 2'b10);
        bad     = ((Size == SZ_HALF) && Addr[0])
                || ((Size == SZ_WORD) && (Addr[1:0] != 2'b00))
                || ((Addr[31:2] >> DEPTH_BITS) != 30'd0);
        take    = (state == IDLE) && Req && size_ok && !RESET;
        err_go  = take && bad;
        load_go = take && !bad && !IsStore;
        sw_go   = take && !bad && IsStore && (Size == SZ_WORD);
        rmw_go  = take && !bad && IsStore && (Size != SZ_WORD);
    end

    // Big-endian lane select and extension for loads.
    always_comb begin
        lane_byte = MemReadData[31:24];
        case (Addr[1:0])
            2'd0: lane_byte = MemReadData[31:24];
            2'd1: lane_byte = MemReadData[23:16];
            2'd2: lane_byte = MemReadData[15:8];
            2'd3: lane_byte = MemReadData[7:0];
            default: lane_byte = MemReadData[31:24];
        endcase
        lane_half = Addr[1] ? MemReadData[15:0] : MemReadData[31:16];
        case (Size)
            SZ_BYTE: load_ext = {{24{~Unsigned & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_ext = {{16{~Unsigned & lane_half[15]}}, lane_half};
            default: load_ext = MemReadData;
        endcase
    end

    // Merge the store byte/half into the current memory word.
    always_comb begin
        merged = MemReadData;
        if (Size == SZ_BYTE) begin
            case (Addr[1:0])
                2'd0: merged = {StoreData[7:0], MemReadData[23:0]};
                2'd1: merged = {MemReadData[31:24], StoreData[7:0], MemReadData[15:0]};
                2'd2: merged = {MemReadData[31:16], StoreData[7:0], MemReadData[7:0]};
                2'd3: merged = {MemReadData[31:8], StoreData[7:0]};
                default: merged = MemReadData;
            endcase
        end else if (Size == SZ_HALF) begin
            merged = Addr[1] ? {MemReadData[31:16], StoreData[15:0]}
                             : {StoreData[15:0], MemReadData[15:0]};
        end
    end

    // FSM next state and memory-side outputs.
    always_comb begin
        state_nxt      = state;
        Stall          = 1'b0;
        MemWriteEnable = 1'b0;
        MemWriteData   = StoreData;
        MemAddress     = {Addr[31:2], 2'b00};
        case (state)
            IDLE: begin
                Stall          = rmw_go;
                MemWriteEnable = sw_go;
                if (rmw_go) state_nxt = RMW_WRITE;
            end
            RMW_WRITE: begin
                MemAddress     = {rmw_addr, 2'b00};
                MemWriteData   = rmw_data;
                MemWriteEnable = !RESET;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            LoadData  <= 32'd0;
            LoadValid <= 1'b0;
            AddrError <= 1'b0;
            rmw_addr  <= 30'd0;
            rmw_data  <= 32'd0;
        end else begin
            state     <= state_nxt;
            LoadValid <= load_go;
            AddrError <= err_go;
            if (load_go) LoadData <= load_ext;
            if (rmw_go) begin
                rmw_addr <= Addr[31:2];
                rmw_data <= merged;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table driven back-to-back, scoreboard of
// expected loads/writes/errors, plus a reset-during-RMW sequence.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Req;
    logic        IsStore;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        Stall;
    logic [31:0] LoadData;
    logic        LoadValid;
    logic        AddrError;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWriteEnable;
    logic [31:0] MemReadData;

    load_store_unit #(.DEPTH_BITS(6)) dut (
        .CLK(CLK), .RESET(RESET), .Req(Req), .IsStore(IsStore), .Size(Size),
        .Unsigned(Unsigned), .Addr(Addr), .StoreData(StoreData), .Stall(Stall),
        .LoadData(LoadData), .LoadValid(LoadValid), .AddrError(AddrError),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWriteEnable(MemWriteEnable), .MemReadData(MemReadData)
    );

    always #5 CLK = ~CLK;

    // 64-word memory: combinational read, write at the clock edge.
    logic [31:0] mem [64];
    assign MemReadData = mem[MemAddress[7:2]];
    always @(posedge CLK) if (MemWriteEnable) mem[MemAddress[7:2]] <= MemWriteData;

    typedef enum int {K_NONE, K_LD, K_WR, K_ERR} kind_e;
    typedef struct {
        bit          is_store;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] data;
        kind_e       kind;
        logic [31:0] exp;
        logic [31:0] waddr;
        int          stall;
    } vec_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    vec_t        vecs[$];
    logic [31:0] exp_load[$];
    wr_t         exp_wr[$];
    int          exp_err;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s @%0t", name, $time);
    endtask

    // Scoreboard: every DUT event must match the head of its expectation queue.
    always @(negedge CLK) if (mon_en) begin
        if (LoadValid && AddrError) flag("loadvalid_and_addrerror");
        if (LoadValid) begin
            if (exp_load.size() == 0) flag("unexpected_loadvalid");
            else check("load_data", LoadData, exp_load.pop_front());
        end
        if (AddrError) begin
            if (exp_err == 0) flag("unexpected_addrerror");
            else begin exp_err--; n_cmp++; end
        end
        if (MemWriteEnable) begin
            if (exp_wr.size() == 0) flag("unexpected_write");
            else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("write_addr", MemAddress, w.addr);
                check("write_data", MemWriteData, w.data);
            end
        end
    end

    // Present one request, holding it through any stall; counts stall cycles.
    task automatic do_req(input vec_t v);
        int st;
        bit done;
        st = 0;
        done = 1'b0;
        Req = 1'b1; IsStore = v.is_store; Size = v.size; Unsigned = v.uns;
        Addr = v.addr; StoreData = v.data;
        case (v.kind)
            K_LD:  exp_load.push_back(v.exp);
            K_WR:  exp_wr.push_back('{v.waddr, v.exp});
            K_ERR: exp_err++;
            default: ;
        endcase
        for (int c = 0; c < 4 && !done; c++) begin
            @(negedge CLK);
            if (Stall) st++; else done = 1'b1;
            @(posedge CLK); #1;
        end
        if (!done) flag("stall_timeout");
        check("stall_cycles", 32'(st), 32'(v.stall));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        exp_err = 0;
        RESET = 1'b1; Req = 1'b0; IsStore = 1'b0; Size = 2'b11; Unsigned = 1'b0;
        Addr = 32'd0; StoreData = 32'd0;

        //                st  size   u  addr         data          kind   exp           waddr     stall
        vecs.push_back('{1'b1, 2'b11, 1'b0, 32'h08, 32'h11223344, K_WR,  32'h11223344, 32'h08, 0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h08, 32'h0,        K_LD,  32'h11223344, 32'h0,  0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0A, 32'h000000AB, K_WR,  32'h1122AB44, 32'h08, 1});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h08, 32'h0,        K_LD,  32'h1122AB44, 32'h0,  0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        K_LD,  32'hFFFFAB44, 32'h0,  0});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0A, 32'h0,        K_LD,  32'h0000AB44, 32'h0,  0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h09, 32'h0,        K_LD,  32'h00000022, 32'h0,  0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0A, 32'h0,        K_LD,  32'hFFFFFFAB, 32'h0,  0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h08, 32'h0,        K_LD,  32'h00000011, 32'h0,  0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h08, 32'h0,        K_LD,  32'h00001122, 32'h0,  0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0B, 32'h0,        K_LD,  32'h00000044, 32'h0,  0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h06, 32'h0,        K_ERR, 32'h0,        32'h0,  0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h03, 32'h1234,     K_ERR, 32'h0,        32'h0,  0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h100, 32'h0,       K_ERR, 32'h0,        32'h0,  0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h08, 32'h55,       K_NONE, 32'h0,       32'h0,  0});
        vecs.push_back('{1'b1, 2'b11, 1'b0, 32'hFC, 32'hCAFEF00D, K_WR,  32'hCAFEF00D, 32'hFC, 0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'hFC, 32'h0,        K_LD,  32'hCAFEF00D, 32'h0,  0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0C, 32'h0000BEEF, K_WR,  32'hBEEF0000, 32'h0C, 1});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0D, 32'h0,        K_LD,  32'h000000EF, 32'h0,  0});

        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK);
        check("rst_loadvalid", 32'(LoadValid), 32'd0);
        check("rst_addrerror", 32'(AddrError), 32'd0);
        check("rst_loaddata", LoadData, 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_we", 32'(MemWriteEnable), 32'd0);
        @(posedge CLK); #1;

        foreach (vecs[i]) do_req(vecs[i]);
        Req = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset lands while the SB is in its write cycle: the write must be dropped.
        Req = 1'b1; IsStore = 1'b1; Size = 2'b00; Unsigned = 1'b0;
        Addr = 32'h08; StoreData = 32'h000000FF;
        @(negedge CLK);
        check("rmw_rst_stall", 32'(Stall), 32'd1);
        @(posedge CLK); #1 RESET = 1'b1;
        @(negedge CLK);
        check("rmw_rst_we", 32'(MemWriteEnable), 32'd0);
        check("rmw_rst_stall2", 32'(Stall), 32'd0);
        @(posedge CLK); #1 RESET = 1'b0; Req = 1'b0;
        @(negedge CLK);
        check("post_rst_loaddata", LoadData, 32'd0);
        check("post_rst_loadvalid", 32'(LoadValid), 32'd0);
        check("post_rst_addrerror", 32'(AddrError), 32'd0);
        check("post_rst_we", 32'(MemWriteEnable), 32'd0);
        @(posedge CLK); #1;
        do_req('{1'b0, 2'b11, 1'b0, 32'h08, 32'h0, K_LD, 32'h1122AB44, 32'h0, 0});
        Req = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        check("pending_loads", 32'(exp_load.size()), 32'd0);
        check("pending_writes", 32'(exp_wr.size()), 32'd0);
        check("pending_errors", 32'(exp_err), 32'd0);
        for (int i = 0; i < 64; i++) begin
            logic [31:0] e;
            case (i)
                2:  e = 32'h1122AB44;
                3:  e = 32'hBEEF0000;
                63: e = 32'hCAFEF00D;
                default: e = 32'h0;
            endcase
            check($sformatf("mem_word_%0d", i), mem[i], e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
